// File: rtl/mem_resp_stage_if.sv
// Bus bundle for mem_resp_stage: EX handshake, WB handshake, data-SRAM response,
// flush and the per-entry forwarding vector.
// MEM_ALE_CHECK_EN widens to_WB_data by one bit, which carries the ale flag.
interface mem_resp_stage_if #(
  parameter int unsigned DEPTH = 2
);
`ifdef MEM_ALE_CHECK_EN
  localparam int unsigned WbW = 71;
`else
  localparam int unsigned WbW = 70;
`endif

  logic                   EX_to_MEM_valid;
  logic                   MEM_allow_in;
  logic [74:0]            to_MEM_data;
  logic                   WB_allow_in;
  logic                   MEM_to_WB_valid;
  logic [WbW-1:0]         to_WB_data;
  logic                   data_sram_data_ok;
  logic [31:0]            data_sram_rdata;
  logic                   flush;
  logic [DEPTH*39-1:0]    MEM_forward;

  // Pipeline/memory side that drives the stage.
  modport master (
    output EX_to_MEM_valid, to_MEM_data, WB_allow_in, data_sram_data_ok, data_sram_rdata,
           flush,
    input  MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_forward
  );

  // The stage itself.
  modport slave (
    input  EX_to_MEM_valid, to_MEM_data, WB_allow_in, data_sram_data_ok, data_sram_rdata,
           flush,
    output MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_forward
  );
endinterface

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: in-order DEPTH-entry buffer between EX and WB. Absorbs
// variable-latency data-SRAM responses, extracts/extends load data, forwards
// per-entry results and drops responses that were in flight at a flush.
// Optional feature macro: MEM_ALE_CHECK_EN (misaligned-load flag on to_WB_data).
module mem_resp_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_resp_stage_if.slave io_bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ld_b;
    logic        ld_h;
    logic        ld_w;
    logic        ld_signed;
    logic [1:0]  addr;
  } ent_t;

  ent_t             r_ent [DEPTH];
  logic [31:0]      r_res [DEPTH];
  logic [DEPTH-1:0] r_valid, r_wait;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count, r_discard;

  logic [DEPTH-1:0] w_valid_d, w_wait_d;
  logic [PW-1:0]    w_head_d, w_tail_d, w_rsp_idx;
  logic [CW-1:0]    w_count_d, w_discard_d, w_wait_left;
  logic [CW:0]      w_occ;
  logic             w_wb_valid, w_pop, w_accept, w_found, w_drop, w_clear, w_sel_ld;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load, w_in_alu;
  ent_t             w_sel, w_head_ent, w_in_ent;

`ifdef MEM_ALE_CHECK_EN
  function automatic logic ale_of(input ent_t e);
    return (e.ld_h & e.addr[0]) | (e.ld_w & (e.addr != 2'b00));
  endfunction
`endif

  // Unpack the EX bundle (MSB first: pc, alu_result, ld_b/h/w, signed, mem_req, dest, gr_we).
  assign w_in_alu = io_bus.to_MEM_data[42:11];
  assign w_in_ent = '{pc:        io_bus.to_MEM_data[74:43],
                      dest:      io_bus.to_MEM_data[5:1],
                      gr_we:     io_bus.to_MEM_data[0],
                      ld_b:      io_bus.to_MEM_data[10],
                      ld_h:      io_bus.to_MEM_data[9],
                      ld_w:      io_bus.to_MEM_data[8],
                      ld_signed: io_bus.to_MEM_data[7],
                      addr:      w_in_alu[1:0]};

  assign w_head_ent = r_ent[r_head];
  assign w_wb_valid = r_valid[r_head] & ~r_wait[r_head] & ~io_bus.flush;
  assign w_pop      = w_wb_valid & io_bus.WB_allow_in;
  // Slots still owed a response after a flush count against capacity.
  assign w_occ      = {1'b0, r_count} + {1'b0, r_discard};
  assign w_accept   = io_bus.EX_to_MEM_valid & io_bus.MEM_allow_in & ~io_bus.flush;

  assign io_bus.MEM_allow_in    = (w_occ < (CW + 1)'(DEPTH)) | w_pop;
  assign io_bus.MEM_to_WB_valid = w_wb_valid;

  // Find the oldest waiting entry; a response goes there unless it is owed to a flushed one.
  always_comb begin
    w_found   = 1'b0;
    w_rsp_idx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && r_valid[r_head + PW'(k)] && r_wait[r_head + PW'(k)]) begin
        w_found   = 1'b1;
        w_rsp_idx = r_head + PW'(k);
      end
    end
    w_drop  = io_bus.data_sram_data_ok & (r_discard != '0);
    w_clear = io_bus.data_sram_data_ok & (r_discard == '0) & w_found;
  end

  // Byte/halfword extraction with sign or zero extension for the responding entry.
  always_comb begin
    w_sel    = r_ent[w_rsp_idx];
    w_sel_ld = w_sel.ld_b | w_sel.ld_h | w_sel.ld_w;
    w_byte   = '0;
    case (w_sel.addr)
      2'd0:    w_byte = io_bus.data_sram_rdata[7:0];
      2'd1:    w_byte = io_bus.data_sram_rdata[15:8];
      2'd2:    w_byte = io_bus.data_sram_rdata[23:16];
      default: w_byte = io_bus.data_sram_rdata[31:24];
    endcase
    w_half = w_sel.addr[1] ? io_bus.data_sram_rdata[31:16] : io_bus.data_sram_rdata[15:0];
    if (w_sel.ld_b)      w_load = {{24{w_sel.ld_signed & w_byte[7]}}, w_byte};
    else if (w_sel.ld_h) w_load = {{16{w_sel.ld_signed & w_half[15]}}, w_half};
    else                 w_load = io_bus.data_sram_rdata;
`ifdef MEM_ALE_CHECK_EN
    if (ale_of(w_sel)) w_load = '0;
`endif
  end

  // Next-state for occupancy, pointers, valid/waiting bits and the discard counter.
  always_comb begin
    w_valid_d   = r_valid;
    w_wait_d    = r_wait;
    w_head_d    = r_head;
    w_tail_d    = r_tail;
    w_count_d   = r_count;
    w_discard_d = r_discard;
    w_wait_left = '0;
    if (w_clear) w_wait_d[w_rsp_idx] = 1'b0;
    if (w_pop) begin
      w_valid_d[r_head] = 1'b0;
      w_head_d          = r_head + PW'(1);
    end
    if (w_accept) begin
      w_valid_d[r_tail] = 1'b1;
      w_wait_d[r_tail]  = io_bus.to_MEM_data[6];
      w_tail_d          = r_tail + PW'(1);
    end
    unique case ({w_accept, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
    if (w_drop) w_discard_d = r_discard - CW'(1);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_wait[i] && !(w_clear && (w_rsp_idx == PW'(i)))) begin
        w_wait_left = w_wait_left + CW'(1);
      end
    end
    if (io_bus.flush) begin
      w_valid_d   = '0;
      w_wait_d    = '0;
      w_head_d    = r_tail;
      w_count_d   = '0;
      w_discard_d = w_discard_d + w_wait_left;
    end
  end

  // State registers; synchronous reset forgets any outstanding responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_wait    <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_discard <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
        r_res[i] <= '0;
      end
    end else begin
      r_valid   <= w_valid_d;
      r_wait    <= w_wait_d;
      r_head    <= w_head_d;
      r_tail    <= w_tail_d;
      r_count   <= w_count_d;
      r_discard <= w_discard_d;
      if (w_clear && w_sel_ld) r_res[w_rsp_idx] <= w_load;
      if (w_accept) begin
        r_ent[r_tail] <= w_in_ent;
        r_res[r_tail] <= w_in_alu;
      end
    end
  end

  // Head entry to WB, zeroed when nothing is leaving.
  always_comb begin
    io_bus.to_WB_data = '0;
    if (w_wb_valid) begin
`ifdef MEM_ALE_CHECK_EN
      io_bus.to_WB_data = {w_head_ent.pc, w_head_ent.dest, r_res[r_head], w_head_ent.gr_we,
                           ale_of(w_head_ent)};
`else
      io_bus.to_WB_data = {w_head_ent.pc, w_head_ent.dest, r_res[r_head], w_head_ent.gr_we};
`endif
    end
  end

  // Per-entry forwarding slices {valid, pending, dest, data}; empty slots read as zero.
  always_comb begin
    io_bus.MEM_forward = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        io_bus.MEM_forward[39*i +: 39] = {1'b1,
                                          r_wait[i] & (r_ent[i].ld_b | r_ent[i].ld_h |
                                                       r_ent[i].ld_w),
                                          r_ent[i].dest, r_res[i]};
      end
    end
  end
endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: table of single transactions plus hand sequences for
// back-pressure, flush-with-discard and mid-operation reset. WB output is checked
// against a scoreboard queue filled at acceptance.
module tb_mem_resp_stage;
  localparam int unsigned DEPTH = 2;
`ifdef MEM_ALE_CHECK_EN
  localparam int unsigned WbW = 71;
  localparam bit          Ale = 1'b1;
`else
  localparam int unsigned WbW = 70;
  localparam bit          Ale = 1'b0;
`endif
  localparam logic [3:0] LbS = 4'b1001, LbU = 4'b1000, LhS = 4'b0101, LhU = 4'b0100;
  localparam logic [3:0] Lw  = 4'b0010, NoLd = 4'b0000;
  localparam int NV = 10;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        ld_b, ld_h, ld_w, sgn, mem_req;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_res;
    logic        exp_ale;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_resp_stage_if #(.DEPTH(DEPTH)) bus ();
  mem_resp_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .io_bus(bus));

  int             n_total = 0;
  int             n_pass  = 0;
  logic [WbW-1:0] exp_q[$];
  logic [WbW-1:0] e_mon;
  vec_t           vecs[NV];
  vec_t           va, vb, vc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] alu,
                              input logic [3:0] ld, input logic mreq, input logic [4:0] dest,
                              input logic we, input logic [31:0] rdata, input int dly,
                              input logic [31:0] res, input logic ale);
    vec_t v;
    v.pc = pc; v.alu = alu;
    v.ld_b = ld[3]; v.ld_h = ld[2]; v.ld_w = ld[1]; v.sgn = ld[0];
    v.mem_req = mreq; v.dest = dest; v.gr_we = we; v.rdata = rdata; v.delay = dly;
    v.exp_res = res; v.exp_ale = ale;
    return v;
  endfunction

  function automatic logic [74:0] pack(input vec_t v);
    return {v.pc, v.alu, v.ld_b, v.ld_h, v.ld_w, v.sgn, v.mem_req, v.dest, v.gr_we};
  endfunction

  function automatic logic [WbW-1:0] wb_exp(input vec_t v);
`ifdef MEM_ALE_CHECK_EN
    return {v.pc, v.dest, v.exp_res, v.gr_we, v.exp_ale};
`else
    return {v.pc, v.dest, v.exp_res, v.gr_we};
`endif
  endfunction

  function automatic logic pending_any();
    logic p = 1'b0;
    for (int i = 0; i < DEPTH; i++) p = p | bus.MEM_forward[39*i+37];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry until accepted; expectation is queued at the accepting cycle.
  task automatic send(input vec_t v);
    int   n   = 0;
    logic acc = 1'b0;
    bus.EX_to_MEM_valid = 1'b1;
    bus.to_MEM_data     = pack(v);
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.MEM_allow_in && !bus.flush;
      if (acc) exp_q.push_back(wb_exp(v));
      step();
      n++;
    end
    bus.EX_to_MEM_valid = 1'b0;
    if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic respond(input logic [31:0] d);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = d;
    step();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  // Scoreboard: compare every WB handoff with the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.MEM_to_WB_valid && bus.WB_allow_in) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 128'(bus.MEM_to_WB_valid), 128'(0));
      end else begin
        e_mon = exp_q.pop_front();
        chk("wb_data", 128'(bus.to_WB_data), 128'(e_mon));
      end
    end
  end

  initial begin
    vecs[0] = mk(32'h1c000000, 32'h00001234, NoLd, 1'b0, 5'd3, 1'b1, 32'h0, 0,
                 32'h00001234, 1'b0);
    vecs[1] = mk(32'h1c000004, 32'h10000001, LbS, 1'b1, 5'd4, 1'b1, 32'h00008000, 3,
                 32'hFFFFFF80, 1'b0);
    vecs[2] = mk(32'h1c000008, 32'h10000003, LbU, 1'b1, 5'd5, 1'b1, 32'h80000000, 0,
                 32'h00000080, 1'b0);
    vecs[3] = mk(32'h1c00000c, 32'h10000002, LhS, 1'b1, 5'd6, 1'b1, 32'h80010000, 1,
                 32'hFFFF8001, 1'b0);
    vecs[4] = mk(32'h1c000010, 32'h10000000, LhU, 1'b1, 5'd7, 1'b1, 32'h1234F00D, 2,
                 32'h0000F00D, 1'b0);
    vecs[5] = mk(32'h1c000014, 32'h10000000, Lw, 1'b1, 5'd8, 1'b1, 32'hDEADBEEF, 0,
                 32'hDEADBEEF, 1'b0);
    vecs[6] = mk(32'h1c000018, 32'h00000100, NoLd, 1'b1, 5'd0, 1'b0, 32'h55555555, 1,
                 32'h00000100, 1'b0);
    vecs[7] = mk(32'h1c00001c, 32'h10000002, Lw, 1'b1, 5'd9, 1'b1, 32'hCAFEF00D, 1,
                 Ale ? 32'h0 : 32'hCAFEF00D, Ale);
    vecs[8] = mk(32'h1c000020, 32'h10000002, LbS, 1'b1, 5'd10, 1'b1, 32'h007F0000, 0,
                 32'h0000007F, 1'b0);
    vecs[9] = mk(32'h1c000024, 32'h10000001, LhS, 1'b1, 5'd11, 1'b1, 32'h00009000, 0,
                 Ale ? 32'h0 : 32'hFFFF9000, Ale);

    reset = 1'b1;
    bus.EX_to_MEM_valid = 1'b0; bus.to_MEM_data = '0; bus.WB_allow_in = 1'b1;
    bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0; bus.flush = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_allow", 128'(bus.MEM_allow_in), 128'(1));
    chk("rst_wb_valid", 128'(bus.MEM_to_WB_valid), 128'(0));
    chk("rst_wb_data", 128'(bus.to_WB_data), 128'(0));
    chk("rst_forward", 128'(bus.MEM_forward), 128'(0));

    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      if (vecs[i].mem_req) begin
        chk($sformatf("v%0d_pending", i), 128'(pending_any()),
            128'(vecs[i].ld_b | vecs[i].ld_h | vecs[i].ld_w));
        chk($sformatf("v%0d_hold", i), 128'(bus.MEM_to_WB_valid), 128'(0));
        repeat (vecs[i].delay) step();
        respond(vecs[i].rdata);
      end
      chk($sformatf("v%0d_wb_valid", i), 128'(bus.MEM_to_WB_valid), 128'(1));
      drain();
    end

    // Back-pressure: fill both slots, then accept and pop in the same cycle.
    va = mk(32'h1c000100, 32'h20000002, LhU, 1'b1, 5'd12, 1'b1, 32'h0, 0, 32'h0000AAAA, 1'b0);
    vb = mk(32'h1c000104, 32'h20000004, Lw, 1'b1, 5'd13, 1'b1, 32'h0, 0, 32'h12345678, 1'b0);
    vc = mk(32'h1c000108, 32'h0000BEEF, NoLd, 1'b0, 5'd14, 1'b1, 32'h0, 0, 32'h0000BEEF, 1'b0);
    bus.WB_allow_in = 1'b0;
    send(va);
    send(vb);
    chk("full_allow", 128'(bus.MEM_allow_in), 128'(0));
    respond(32'hAAAA5555);
    respond(32'h12345678);
    chk("full_stall_valid", 128'(bus.MEM_to_WB_valid), 128'(1));
    chk("full_stall_allow", 128'(bus.MEM_allow_in), 128'(0));
    bus.WB_allow_in = 1'b1;
    #1;
    chk("full_pop_allow", 128'(bus.MEM_allow_in), 128'(1));
    send(vc);
    chk("full_both_valid", 128'({bus.MEM_forward[77], bus.MEM_forward[38]}), 128'(2'b11));
    drain();

    // Flush with two loads in flight; one response lands in the flush cycle.
    va = mk(32'h1c000200, 32'h30000000, Lw, 1'b1, 5'd15, 1'b1, 32'h0, 0, 32'h0, 1'b0);
    vb = mk(32'h1c000204, 32'h30000004, Lw, 1'b1, 5'd16, 1'b1, 32'h0, 0, 32'h0, 1'b0);
    vc = mk(32'h1c000208, 32'h30000000, LbU, 1'b1, 5'd17, 1'b1, 32'h0, 0, 32'h000000C3, 1'b0);
    send(va);
    send(vb);
    bus.flush = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'h11111111;
    exp_q.delete();
    step();
    bus.flush = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata = '0;
    #1;
    chk("flush_wb_valid", 128'(bus.MEM_to_WB_valid), 128'(0));
    chk("flush_forward", 128'(bus.MEM_forward), 128'(0));
    chk("flush_allow", 128'(bus.MEM_allow_in), 128'(1));
    send(vc);
    chk("disc_allow_full", 128'(bus.MEM_allow_in), 128'(0));
    respond(32'hFFFFFFFF);
    chk("disc_still_pending", 128'(pending_any()), 128'(1));
    chk("disc_no_wb", 128'(bus.MEM_to_WB_valid), 128'(0));
    chk("disc_allow_after", 128'(bus.MEM_allow_in), 128'(1));
    respond(32'h000000C3);
    chk("disc_next_wb_valid", 128'(bus.MEM_to_WB_valid), 128'(1));
    drain();

    // Reset with two entries outstanding.
    send(va);
    send(vb);
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    #1;
    chk("mrst_wb_valid", 128'(bus.MEM_to_WB_valid), 128'(0));
    chk("mrst_forward", 128'(bus.MEM_forward), 128'(0));
    chk("mrst_allow", 128'(bus.MEM_allow_in), 128'(1));
    respond(32'h5A5A5A5A);
    chk("stray_forward", 128'(bus.MEM_forward), 128'(0));
    chk("stray_allow", 128'(bus.MEM_allow_in), 128'(1));
    vc = mk(32'h1c000300, 32'h00000777, NoLd, 1'b0, 5'd18, 1'b1, 32'h0, 0, 32'h00000777, 1'b0);
    send(vc);
    chk("mrst_alu_wb_valid", 128'(bus.MEM_to_WB_valid), 128'(1));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_resp_stage.md
# mem_resp_stage

Parametrised memory-response pipeline stage sitting between EX and WB, replacing the single-entry, fixed-latency MEM stage. It holds up to DEPTH in-order entries, absorbs variable-latency data-SRAM responses via `data_sram_data_ok`, and performs load byte/halfword extraction with sign/zero extension. It provides per-entry forwarding with a pending flag, and on flush it discards responses that are still in flight.

## Interface
- DEPTH, 2, entry count; power of two, ≥2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- EX_to_MEM_valid  in  1  EX offers an entry.
- MEM_allow_in  out  1  MEM can accept this cycle.
- to_MEM_data  in  75  fields, MSB first:
  - pc[32], alu_result[32]
  - ld_b, ld_h, ld_w, ld_signed
  - mem_req: EX issued a data-SRAM request this handshake
  - dest[5], gr_we
- WB_allow_in  in  1  WB accepts.
- MEM_to_WB_valid  out  1  head entry is leaving.
- to_WB_data  out  70 (71 with MEM_ALE_CHECK_EN)  {pc, dest, final_result, gr_we[, ale]}.
- data_sram_data_ok  in  1  one in-order response (load or store).
- data_sram_rdata  in  32  response data.
- flush  in  1  kill all entries.
- MEM_forward  out  DEPTH*39  per entry i, slice [39i+38:39i] = {valid, pending, dest[5], data[32]}.

## Operation
- Storage: circular buffer with head/tail pointers and count (0..DEPTH).
- Per-entry state: bundle, waiting bit, result[32].
- Accept: when EX_to_MEM_valid & MEM_allow_in & ~flush.
  - Write the entry at tail; waiting = mem_req.
  - result = alu_result.
- MEM_allow_in = (count + discard_cnt < DEPTH) | (MEM_to_WB_valid & WB_allow_in).
- Response handling on data_sram_data_ok:
  - If discard_cnt ≠ 0: decrement discard_cnt; data is dropped.
  - Else: the oldest valid entry with waiting=1 clears waiting.
    - If ld_b/ld_h/ld_w, result = extracted load data.
    - Stores keep result = alu_result.
  - data_ok with nothing waiting and discard_cnt=0 is a protocol violation; it is ignored with no state change.
- Load extraction, addr = alu_result[1:0]:
  - ld_b: byte addr.
  - ld_h: halfword addr[1].
  - ld_w: full word.
  - ld_signed selects sign extension, otherwise zero extension.
- Head ready = valid & ~waiting.
- MEM_to_WB_valid = head ready & ~flush.
- Pop on MEM_to_WB_valid & WB_allow_in.
- to_WB_data = head fields with final_result = result; all-zero when MEM_to_WB_valid=0.
- Forward, per entry:
  - valid = entry valid.
  - pending = waiting & (ld_b|ld_h|ld_w).
  - dest = dest & {5{valid}}.
  - data = result.
  - Non-valid slices are all-zero.
- Flush:
  - All entries are invalidated at the edge; count = 0, head = tail.
  - discard_cnt += number of waiting entries remaining after this cycle's data_ok is applied.
  - No pop occurs in the flush cycle.
- discard_cnt width: clog2(DEPTH)+1; never exceeds DEPTH by construction of MEM_allow_in.

## Timing
- Reset:
  - count=0, discard_cnt=0, all valid/waiting=0.
  - MEM_to_WB_valid=0, MEM_allow_in=1, to_WB_data=0, MEM_forward=0.
- Non-mem entry: accepted at edge t, leaves at edge t+1 at the earliest.
- Mem entry: leaves at edge max(t_accept, t_data_ok)+1 at the earliest.
  - rdata is registered; there is no combinational rdata→WB path.
  - data_ok in the same cycle as acceptance belongs to an older waiting entry or to discard, never to the entry being accepted.
- Full (count=DEPTH) with head popping: accept and pop in the same cycle; count unchanged.
- Empty: MEM_to_WB_valid=0; forward slices 0.
- Pointers wrap modulo DEPTH.
- Reset mid-operation: all state cleared; outstanding responses are not tracked after reset.

## Configuration
- MEM_ALE_CHECK_EN defined:
  - ale = (ld_h & addr[0]) | (ld_w & addr[1:0]≠0), appended as LSB of to_WB_data (71 bits).
  - An ale entry forces result=0 once its response arrives.
- MEM_ALE_CHECK_EN undefined:
  - No ale bit; to_WB_data is 70 bits.
  - ld_h uses addr[1] only and ld_w ignores addr; no misalignment detection.

## Test plan
- DEPTH=2, ALU op pc=0x1c000000, alu_result=0x1234, dest=3, WB_allow_in=1 → MEM_to_WB_valid one cycle after accept, to_WB_data={0x1c000000, 3, 0x1234, 1}.
- ld_b signed at addr 0x...01, data_ok 3 cycles later with rdata=0x0000_8000 → forward pending=1 until response; final_result 0xFFFFFF80 one cycle after data_ok.
- Two loads back-to-back, responses 0xAAAA5555 then 0x12345678 with WB_allow_in=0 → MEM_allow_in=0 at count=2; release WB → in-order results ld_h unsigned at addr 2 = 0x0000AAAA, then ld_w = 0x12345678.
- Two waiting loads, flush asserted together with one data_ok → discard_cnt=1; next data_ok dropped; MEM_allow_in=1 again afterwards; no WB output.
- With MEM_ALE_CHECK_EN, ld_w at addr 0x...02 → ale=1, final_result=0; without the macro → result = raw word.
- Reset asserted with count=2 → next cycle MEM_to_WB_valid=0, MEM_forward=0, MEM_allow_in=1.
